bram_access_arbiter: RTL and testbench

//  Shares the 16-entry x MEM_SIZE-bit board-state BRAM between the game engine (read/write)
//  and the VGA display renderer (read-only). Serialises accesses through a 3-state FSM,

---
 rtl/bram_access_arbiter_pkg.sv | 18 +
 rtl/bram_access_arbiter_if.sv | 36 +++
 rtl/bram_rr_pick.sv | 42 ++++
 rtl/bram_access_arbiter.sv | 98 +++++++++
 tb/tb_bram_access_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_access_arbiter_pkg.sv
// Shared types and default sizes for the board-state BRAM access arbiter.
package bram_access_arbiter_pkg;

   localparam int unsigned MemSizeDef = 256;
   localparam int unsigned AddrWDef   = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StResp  = 2'd2
   } state_e;

   typedef enum logic {
      PortEng  = 1'b0,
      PortDisp = 1'b1
   } port_e;

endpackage

// File: rtl/bram_access_arbiter_if.sv
// Engine, display and BRAM-side signals of the arbiter; slave = arbiter, master = requesters/BRAM.
interface bram_access_arbiter_if
   import bram_access_arbiter_pkg::*;
#(
   parameter int unsigned MEM_SIZE = MemSizeDef,
   parameter int unsigned ADDR_W   = AddrWDef
);

   logic                eng_req;
   logic                eng_we;
   logic [ADDR_W-1:0]   eng_addr;
   logic [MEM_SIZE-1:0] eng_wdata;
   logic                eng_done;
   logic [MEM_SIZE-1:0] eng_rdata;

   logic                disp_req;
   logic [ADDR_W-1:0]   disp_addr;
   logic                disp_done;
   logic [MEM_SIZE-1:0] disp_rdata;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [MEM_SIZE-1:0] mem_din;
   logic [MEM_SIZE-1:0] mem_dout;

   modport slave (
      input  eng_req, eng_we, eng_addr, eng_wdata, disp_req, disp_addr, mem_dout,
      output eng_done, eng_rdata, disp_done, disp_rdata, mem_we, mem_addr, mem_din
   );

   modport master (
      output eng_req, eng_we, eng_addr, eng_wdata, disp_req, disp_addr, mem_dout,
      input  eng_done, eng_rdata, disp_done, disp_rdata, mem_we, mem_addr, mem_din
   );

endinterface

// File: rtl/bram_rr_pick.sv
// Two-way winner select. Round-robin by default; ARB_DISP_PRIORITY_EN gives display fixed priority.
module bram_rr_pick
   import bram_access_arbiter_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  eng_req,
   input  logic  disp_req,
   input  logic  update,
   output logic  valid,
   output port_e winner
);

   assign valid = eng_req | disp_req;

`ifdef ARB_DISP_PRIORITY_EN
   // Raster fetch deadline: display always wins, no history kept.
   logic unused_pick;
   assign unused_pick = ^{clk, rst_n, update};
   assign winner      = disp_req ? PortDisp : PortEng;
`else
   port_e last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PortEng;
      end else if (update) begin
         last_q <= winner;
      end
   end

   always_comb begin
      winner = PortEng;
      if (eng_req && disp_req) begin
         winner = (last_q == PortEng) ? PortDisp : PortEng;
      end else if (disp_req) begin
         winner = PortDisp;
      end
   end
`endif

endmodule

// File: rtl/bram_access_arbiter.sv
// Sole BRAM master: serialises engine/display accesses through IDLE -> GRANT -> RESP.
// Optional macro ARB_DISP_PRIORITY_EN selects fixed display priority instead of round-robin.
module bram_access_arbiter
   import bram_access_arbiter_pkg::*;
#(
   parameter int unsigned MEM_SIZE = MemSizeDef,
   parameter int unsigned ADDR_W   = AddrWDef
)
(
   input logic                  clk,
   input logic                  rst_n,
   bram_access_arbiter_if.slave bus
);

   state_e              state_q, state_d;
   port_e               grant_q, grant_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [MEM_SIZE-1:0] mem_din_q, mem_din_d;

   logic  pick_valid;
   port_e pick_winner;
   logic  take;

   bram_rr_pick u_pick (
      .clk      (clk),
      .rst_n    (rst_n),
      .eng_req  (bus.eng_req),
      .disp_req (bus.disp_req),
      .update   (take),
      .valid    (pick_valid),
      .winner   (pick_winner)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      take       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               take    = 1'b1;
               grant_d = pick_winner;
               state_d = StGrant;
               if (pick_winner == PortEng) begin
                  mem_we_d   = bus.eng_we;
                  mem_addr_d = bus.eng_addr;
                  mem_din_d  = bus.eng_wdata;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.disp_addr;
               end
            end
         end
         // BRAM captures address (and write) on the edge that closes this state.
         StGrant: begin
            mem_we_d = 1'b0;
            state_d  = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d  = StIdle;
            mem_we_d = 1'b0;
         end
      endcase
   end

   // Reset drops any in-flight access, including an uncommitted write in GRANT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         grant_q    <= PortEng;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.eng_done   = (state_q == StResp) && (grant_q == PortEng);
   assign bus.disp_done  = (state_q == StResp) && (grant_q == PortDisp);
   assign bus.eng_rdata  = bus.mem_dout;
   assign bus.disp_rdata = bus.mem_dout;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Randomised bench: transaction-level model (shadow memory + arbitration rule) checks every done.
module tb_bram_access_arbiter;
   import bram_access_arbiter_pkg::*;

   localparam int unsigned MS = 256;
   localparam int unsigned AW = 4;
`ifdef ARB_DISP_PRIORITY_EN
   localparam bit DispPrio = 1'b1;
`else
   localparam bit DispPrio = 1'b0;
`endif

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [MS-1:0] data;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bram_access_arbiter_if #(.MEM_SIZE(MS), .ADDR_W(AW)) bus ();

   bram_access_arbiter #(.MEM_SIZE(MS), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Synchronous BRAM: registered address, data out the cycle after the address edge.
   logic [MS-1:0] bram [16];
   logic [MS-1:0] dout_q;
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) bram[bus.mem_addr] <= bus.mem_din;
      dout_q <= bram[bus.mem_addr];
   end
   assign bus.mem_dout = dout_q;

   logic [MS-1:0] shadow [16];
   txn_t          eng_q[$], disp_q[$];
   txn_t          eng_cur, disp_cur;
   bit            eng_act, disp_act, rnd_on, gap_chk;
   int            eng_iss, disp_iss, cyc, eng_lat, disp_prev;
   bit            h_eng [8], h_disp [8], h_we [8];
   logic [AW-1:0] h_addr [8];
   logic [MS-1:0] h_din [8];
   port_e         last_srv;
   port_e         win_log[$];
   logic [MS-1:0] disp_log[$];
   logic [MS-1:0] eng_last_rdata;
   int            n_checks, n_fail;

   task automatic check(input string tag, input logic [MS-1:0] got, input logic [MS-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic txn_t mk(input bit we, input logic [AW-1:0] addr, input logic [MS-1:0] data);
      txn_t t;
      t.we   = we;
      t.addr = addr;
      t.data = data;
      return t;
   endfunction

   function automatic logic [MS-1:0] rnd_word();
      logic [MS-1:0] w;
      for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   // Model: winner decided two cycles before done from the requests seen then.
   task automatic on_done(input port_e p, input txn_t t, input int iss, input logic [MS-1:0] rdata);
      int    n2;
      int    n1;
      int    lat;
      port_e exp_p;
      bit    lat_ok;
      n2  = (cyc + 6) % 8;
      n1  = (cyc + 7) % 8;
      lat = cyc - iss;
      check("req_at_grant", MS'(p == PortEng ? h_eng[n2] : h_disp[n2]), MS'(1));
      if (h_eng[n2] && h_disp[n2]) begin
         exp_p = (DispPrio || last_srv == PortEng) ? PortDisp : PortEng;
      end else begin
         exp_p = h_disp[n2] ? PortDisp : PortEng;
      end
      check("arb_winner", MS'(p), MS'(exp_p));
      last_srv = p;
      win_log.push_back(p);
      // Issued during a RESP and losing one turn is the longest legal wait.
      lat_ok = (lat >= 2) && ((DispPrio && p == PortEng) || lat <= 6);
      check("latency_ok", MS'(lat_ok), MS'(1));
      check("resp_we_low", MS'(bus.mem_we), MS'(0));
      check("grant_addr", MS'(h_addr[n1]), MS'(t.addr));
      if (t.we) begin
         check("we_in_grant", MS'(h_we[n1]), MS'(1));
         check("wr_data", h_din[n1], t.data);
         shadow[t.addr] = t.data;
      end else begin
         check("rd_no_we", MS'(h_we[n1]), MS'(0));
         check(p == PortEng ? "eng_rdata" : "disp_rdata", rdata, shadow[t.addr]);
      end
   endtask

   task automatic drive();
      if (!eng_act) begin
         if (rnd_on && $urandom_range(3) == 0) begin
            eng_q.push_back(mk(1'($urandom_range(1)), AW'($urandom_range(15)), rnd_word()));
         end
         if (eng_q.size() > 0) begin
            eng_cur = eng_q.pop_front();
            eng_act = 1'b1;
            eng_iss = cyc;
         end
      end
      if (!disp_act) begin
         if (rnd_on && $urandom_range(3) == 0) begin
            disp_q.push_back(mk(1'b0, AW'($urandom_range(15)), '0));
         end
         if (disp_q.size() > 0) begin
            disp_cur = disp_q.pop_front();
            disp_act = 1'b1;
            disp_iss = cyc;
         end
      end
      bus.eng_req   = eng_act;
      bus.eng_we    = eng_act ? eng_cur.we : 1'b0;
      bus.eng_addr  = eng_cur.addr;
      bus.eng_wdata = eng_cur.data;
      bus.disp_req  = disp_act;
      bus.disp_addr = disp_cur.addr;
   endtask

   task automatic tick();
      int n1;
      @(negedge clk);
      cyc++;
      n1 = (cyc + 7) % 8;
      if (rst_n) begin
         if (bus.eng_done || bus.disp_done) begin
            check("done_excl", MS'(bus.eng_done & bus.disp_done), MS'(0));
         end
         if (h_we[n1]) check("we_then_wdone", MS'(bus.eng_done && eng_act && eng_cur.we), MS'(1));
         if (bus.eng_done) begin
            check("eng_done_expected", MS'(eng_act), MS'(1));
            if (eng_act) begin
               on_done(PortEng, eng_cur, eng_iss, bus.eng_rdata);
               eng_last_rdata = bus.eng_rdata;
               eng_lat        = cyc - eng_iss;
               eng_act        = 1'b0;
            end
         end
         if (bus.disp_done) begin
            check("disp_done_expected", MS'(disp_act), MS'(1));
            if (disp_act) begin
               on_done(PortDisp, disp_cur, disp_iss, bus.disp_rdata);
               disp_log.push_back(bus.disp_rdata);
               if (gap_chk && disp_prev >= 0) check("disp_gap", MS'(cyc - disp_prev), MS'(3));
               disp_prev = cyc;
               disp_act  = 1'b0;
            end
         end
      end
      h_we[cyc % 8]   = bus.mem_we;
      h_addr[cyc % 8] = bus.mem_addr;
      h_din[cyc % 8]  = bus.mem_din;
      drive();
      h_eng[cyc % 8]  = bus.eng_req;
      h_disp[cyc % 8] = bus.disp_req;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((eng_act || disp_act || eng_q.size() > 0 || disp_q.size() > 0) && k < budget) begin
         tick();
         k++;
      end
      check("drain_complete",
            MS'(eng_act || disp_act || eng_q.size() > 0 || disp_q.size() > 0), MS'(0));
      tick();
   endtask

   initial begin
      logic [MS-1:0] a5;
      logic [MS-1:0] word_x;
      logic [MS-1:0] old_w;
      int            k;
      a5 = {32{8'hA5}};
      for (int i = 0; i < 16; i++) begin
         bram[i]   = rnd_word();
         shadow[i] = bram[i];
      end
      last_srv  = PortEng;
      disp_prev = -1;
      drive();
      repeat (3) tick();

      check("rst_mem_we", MS'(bus.mem_we), MS'(0));
      check("rst_mem_addr", MS'(bus.mem_addr), MS'(0));
      check("rst_mem_din", bus.mem_din, MS'(0));
      check("rst_eng_done", MS'(bus.eng_done), MS'(0));
      check("rst_disp_done", MS'(bus.disp_done), MS'(0));
      rst_n = 1'b1;
      tick();

      eng_q.push_back(mk(1'b1, 4'd3, a5));
      drain(20);
      check("t1_lat", MS'(eng_lat), MS'(2));

      eng_q.push_back(mk(1'b0, 4'd3, '0));
      drain(20);
      check("t2_rdata", eng_last_rdata, a5);

      win_log.delete();
      for (int i = 0; i < 4; i++) begin
         eng_q.push_back(mk(1'b0, AW'($urandom_range(15)), '0));
         disp_q.push_back(mk(1'b0, AW'($urandom_range(15)), '0));
      end
      drain(100);
      check("t3_count", MS'(win_log.size()), MS'(8));
      for (int i = 0; i < 8 && i < win_log.size(); i++) begin
         check("t3_order", MS'(win_log[i]),
               MS'(DispPrio ? (i < 4 ? PortDisp : PortEng) : (i % 2 == 0 ? PortDisp : PortEng)));
      end

      word_x = rnd_word();
      old_w  = shadow[15];
      disp_log.delete();
      eng_q.push_back(mk(1'b1, 4'd15, word_x));
      disp_q.push_back(mk(1'b0, 4'd15, '0));
      drain(30);
      disp_q.push_back(mk(1'b0, 4'd15, '0));
      drain(30);
      check("t4_count", MS'(disp_log.size()), MS'(2));
      if (disp_log.size() == 2) begin
         check("t4_old", disp_log[0], old_w);
         check("t4_new", disp_log[1], word_x);
      end

      old_w = shadow[7];
      eng_q.push_back(mk(1'b1, 4'd7, rnd_word()));
      k = 0;
      while (bus.mem_we !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      check("t5_grant_seen", MS'(bus.mem_we), MS'(1));
      rst_n = 1'b0;
      #1;
      check("t5_we_drop", MS'(bus.mem_we), MS'(0));
      check("t5_eng_done", MS'(bus.eng_done), MS'(0));
      check("t5_disp_done", MS'(bus.disp_done), MS'(0));
      eng_act = 1'b0;
      eng_q.delete();
      for (int i = 0; i < 8; i++) begin
         h_we[i]   = 1'b0;
         h_eng[i]  = 1'b0;
         h_disp[i] = 1'b0;
      end
      last_srv = PortEng;
      repeat (2) tick();
      check("t5_no_done", MS'(bus.eng_done | bus.disp_done | bus.mem_we), MS'(0));
      rst_n = 1'b1;
      tick();
      eng_q.push_back(mk(1'b0, 4'd7, '0));
      drain(20);
      check("t5_word7", eng_last_rdata, old_w);
      check("t5_lat", MS'(eng_lat), MS'(2));

      disp_log.delete();
      gap_chk   = 1'b1;
      disp_prev = -1;
      for (int i = 0; i < 16; i++) disp_q.push_back(mk(1'b0, AW'(i), '0));
      drain(100);
      gap_chk = 1'b0;
      check("t6_count", MS'(disp_log.size()), MS'(16));

      rnd_on = 1'b1;
      repeat (600) tick();
      rnd_on = 1'b0;
      drain(DispPrio ? 400 : 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
